// File: rtl/spi_coef_regfile.sv
// SPI-slave coefficient register file: shadow bank written over SPI, active bank swapped on commit.
// Writes/commits land one clock after the 32nd synchronised SCLK rise; read data streams from bit 9.
module spi_coef_regfile #(
  parameter int NUM_CH = 4,
  parameter int TAPS   = 8,
  parameter int COEF_W = 5
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             SCLK,
  input  logic                             MOSI,
  input  logic                             ss,
  output logic                             MISO,
  output logic [NUM_CH*TAPS*COEF_W-1:0]    coef,
  output logic                             commit_pulse,
  output logic [7:0]                       err_cnt
);

  localparam int NREG = NUM_CH * TAPS;

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic mosi_s1_q, mosi_s2_q;
  logic ss_s1_q, ss_s2_q, ss_s3_q;

  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [30:0]       shift_q, shift_d;
  logic [23:0]       tx_q, tx_d;
  logic              rd_q, rd_d;
  logic              miso_q, miso_d;
  logic              commit_q, commit_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [COEF_W-1:0] shadow_q [NREG];
  logic [COEF_W-1:0] shadow_d [NREG];
  logic [COEF_W-1:0] active_q [NREG];
  logic [COEF_W-1:0] active_d [NREG];

  logic              sclk_rise, sclk_fall, ss_active, ss_rise;
  logic              sample, last_bit, hdr_bit, frame_wr;
  logic [6:0]        frame_addr, rd_addr;
  logic [COEF_W-1:0] wr_val;
  logic [23:0]       rd_src;

  always_comb begin
    sclk_rise  = sclk_s2_q & ~sclk_s3_q;
    sclk_fall  = ~sclk_s2_q & sclk_s3_q;
    ss_active  = ~ss_s2_q;
    ss_rise    = ss_s2_q & ~ss_s3_q;
    sample     = sclk_rise & ss_active & (bit_cnt_q != 6'd32);
    last_bit   = sample & (bit_cnt_q == 6'd31);
    hdr_bit    = sample & (bit_cnt_q == 6'd7);
    // On the final rise the complete frame is {shift_q, MOSI}
    frame_wr   = last_bit & shift_q[30];
    frame_addr = shift_q[29:23];
    wr_val     = COEF_W'({shift_q[22:0], mosi_s2_q});
    // On the 8th rise the header is {shift_q[6:0], MOSI}
    rd_addr    = {shift_q[5:0], mosi_s2_q};

    rd_src = '0;
    if (rd_addr == 7'h7E) begin
      rd_src = {16'h0000, err_cnt_q};
    end
    for (int k = 0; k < NREG; k++) begin
      if (rd_addr == 7'(k)) begin
        rd_src = 24'(shadow_q[k]);
      end
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rd_d      = rd_q;
    commit_d  = 1'b0;
    err_cnt_d = err_cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;

    if (!ss_active) begin
      bit_cnt_d = 6'd0;
      rd_d      = 1'b0;
    end else if (sample) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      shift_d   = {shift_q[29:0], mosi_s2_q};
    end

    if (hdr_bit && !shift_q[6]) begin
      rd_d = 1'b1;
      tx_d = rd_src;
    end else if (rd_q && ss_active && sclk_fall &&
                 bit_cnt_q >= 6'd9 && bit_cnt_q <= 6'd31) begin
      tx_d = {tx_q[22:0], 1'b0};
    end

    for (int k = 0; k < NREG; k++) begin
      if (frame_wr && frame_addr == 7'(k)) begin
        shadow_d[k] = wr_val;
      end
    end

    if (frame_wr && frame_addr == 7'h7F && mosi_s2_q) begin
      active_d = shadow_q;
      commit_d = 1'b1;
    end

    // ss released mid-frame: count it, leave registers untouched
    if (ss_rise && bit_cnt_q != 6'd0 && bit_cnt_q != 6'd32 && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    miso_d = (rd_d && bit_cnt_d >= 6'd8) ? tx_d[23] : 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_s3_q   <= 1'b1;
      bit_cnt_q <= 6'd0;
      shift_q   <= '0;
      tx_q      <= '0;
      rd_q      <= 1'b0;
      miso_q    <= 1'b0;
      commit_q  <= 1'b0;
      err_cnt_q <= 8'd0;
      for (int k = 0; k < NREG; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      sclk_s1_q <= SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      mosi_s1_q <= MOSI;
      mosi_s2_q <= mosi_s1_q;
      ss_s1_q   <= ss;
      ss_s2_q   <= ss_s1_q;
      ss_s3_q   <= ss_s2_q;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      miso_q    <= miso_d;
      commit_q  <= commit_d;
      err_cnt_q <= err_cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    coef = '0;
    for (int k = 0; k < NREG; k++) begin
      coef[k*COEF_W +: COEF_W] = active_q[k];
    end
  end

  assign MISO         = miso_q;
  assign commit_pulse = commit_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_spi_coef_regfile.sv
// Bench for spi_coef_regfile: SPI master stimulus with queued expectations and negedge monitors.
module tb_spi_coef_regfile;

  localparam int HP = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, SCLK, MOSI, ss0, ss1;
  logic         miso0, miso1, cp0, cp1;
  logic [159:0] coef0;
  logic [71:0]  coef1;
  logic [7:0]   err0, err1;

  spi_coef_regfile dut0 (
    .clock(clock), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .ss(ss0),
    .MISO(miso0), .coef(coef0), .commit_pulse(cp0), .err_cnt(err0)
  );

  spi_coef_regfile #(.NUM_CH(2), .TAPS(3), .COEF_W(12)) dut1 (
    .clock(clock), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .ss(ss1),
    .MISO(miso1), .coef(coef1), .commit_pulse(cp1), .err_cnt(err1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { string name; logic [159:0] val; } exp_t;
  typedef struct { string name; int kind; logic [159:0] val; } obs_t;

  exp_t        commit0_q[$];
  exp_t        commit1_q[$];
  exp_t        read_exp_q[$];
  logic [31:0] read_rsp_q[$];
  obs_t        obs_q[$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic spi_frame(input int sel, input logic [31:0] word, input int nbits,
                           input bit end_frame, input bit is_read);
    logic [31:0] rx;
    rx = '0;
    if (sel == 0) ss0 = 1'b0; else ss1 = 1'b0;
    tick(HP);
    for (int i = 0; i < nbits; i++) begin
      MOSI = word[31-i];
      tick(HP);
      rx[31-i] = (sel == 0) ? miso0 : miso1;
      SCLK = 1'b1;
      tick(HP);
      SCLK = 1'b0;
    end
    if (end_frame) begin
      tick(HP);
      if (sel == 0) ss0 = 1'b1; else ss1 = 1'b1;
      tick(8);
      if (is_read) read_rsp_q.push_back(rx);
    end
  endtask

  task automatic spi_write(input int sel, input logic [31:0] word);
    spi_frame(sel, word, 32, 1'b1, 1'b0);
  endtask

  task automatic spi_read(input logic [6:0] addr, input logic [23:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.val  = 160'({8'h00, exp});
    read_exp_q.push_back(e);
    spi_frame(0, {1'b0, addr, 24'h000000}, 32, 1'b1, 1'b1);
  endtask

  task automatic observe(input string name, input int kind, input logic [159:0] val);
    obs_t o;
    o.name = name;
    o.kind = kind;
    o.val  = val;
    obs_q.push_back(o);
    tick(2);
  endtask

  task automatic expect_commit(input int sel, input string name, input logic [159:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    if (sel == 0) commit0_q.push_back(e); else commit1_q.push_back(e);
  endtask

  // Monitors: status observations and read responses
  obs_t        o_cur;
  exp_t        r_exp;
  logic [31:0] r_act;
  always @(negedge clock) begin
    if (obs_q.size() > 0) begin
      o_cur = obs_q.pop_front();
      case (o_cur.kind)
        0:       check(o_cur.name, coef0, o_cur.val);
        1:       check(o_cur.name, 160'(err0), o_cur.val);
        default: check(o_cur.name, 160'(coef1), o_cur.val);
      endcase
    end
    if (read_rsp_q.size() > 0 && read_exp_q.size() > 0) begin
      r_act = read_rsp_q.pop_front();
      r_exp = read_exp_q.pop_front();
      check(r_exp.name, 160'(r_act), r_exp.val);
    end
  end

  // Monitors: commit pulses, with one-cycle width checks
  logic cp0_prev = 1'b0;
  logic cp1_prev = 1'b0;
  exp_t c0_exp, c1_exp;
  always @(negedge clock) begin
    if (cp0_prev) begin
      check("commit0_width", 160'(cp0), 160'd0);
    end else if (cp0) begin
      if (commit0_q.size() == 0) check("commit0_expected", 160'(commit0_q.size()), 160'd1);
      else begin
        c0_exp = commit0_q.pop_front();
        check(c0_exp.name, coef0, c0_exp.val);
      end
    end
    if (cp1_prev) begin
      check("commit1_width", 160'(cp1), 160'd0);
    end else if (cp1) begin
      if (commit1_q.size() == 0) check("commit1_expected", 160'(commit1_q.size()), 160'd1);
      else begin
        c1_exp = commit1_q.pop_front();
        check(c1_exp.name, 160'(coef1), c1_exp.val);
      end
    end
    cp0_prev <= cp0;
    cp1_prev <= cp1;
  end

  initial begin
    reset = 1'b1;
    SCLK  = 1'b0;
    MOSI  = 1'b0;
    ss0   = 1'b1;
    ss1   = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(5);

    observe("rst_coef0", 0, 160'd0);
    observe("rst_err0",  1, 160'd0);
    observe("rst_coef1", 2, 160'd0);

    // Shadow write to addr 5 must not reach coef until commit
    spi_write(0, 32'h85000013);
    observe("coef_before_commit", 0, 160'd0);
    expect_commit(0, "commit_addr5", 160'h26000000);
    spi_write(0, 32'hFF000001);
    observe("coef_after_commit", 0, 160'h26000000);
    spi_read(7'h05, 24'h000013, "read_addr5");

    // Aborted write after 17 bits
    spi_frame(0, 32'h82000007, 17, 1'b1, 1'b0);
    observe("err_after_abort", 1, 160'd1);
    spi_read(7'h02, 24'h000000, "read_addr2_after_abort");
    for (int i = 0; i < 299; i++) spi_frame(0, 32'h82000007, 17, 1'b1, 1'b0);
    spi_read(7'h7E, 24'h0000FF, "read_err_sat");
    observe("err_sat", 1, 160'd255);

    // Ignored writes and a no-op commit
    spi_write(0, 32'hC0000015);
    spi_write(0, 32'hFE00000A);
    spi_write(0, 32'hFF000000);
    observe("coef_after_ignored", 0, 160'h26000000);
    spi_read(7'h40, 24'h000000, "read_unmapped_40");
    spi_read(7'h7E, 24'h0000FF, "read_err_after_ignored");
    spi_read(7'h05, 24'h000013, "read_addr5_again");

    // Reset mid-frame, then a clean write + commit
    spi_frame(0, 32'h81000009, 20, 1'b0, 1'b0);
    reset = 1'b1;
    tick(3);
    ss0 = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5);
    observe("err_after_reset",  1, 160'd0);
    observe("coef_after_reset", 0, 160'd0);
    spi_write(0, 32'h8300001F);
    expect_commit(0, "commit_after_reset", 160'hF8000);
    spi_write(0, 32'hFF000001);
    observe("coef_new_frame_only", 0, 160'hF8000);
    observe("err_still_zero", 1, 160'd0);

    // Alternate geometry: 2 channels x 3 taps x 12 bits
    spi_write(1, 32'h85000ABC);
    expect_commit(1, "commit_dut1", 160'hABC000000000000000);
    spi_write(1, 32'hFF000001);
    observe("coef1_after_commit", 2, 160'hABC000000000000000);
    observe("coef0_untouched", 0, 160'hF8000);

    tick(20);
    check("commit0_drained", 160'(commit0_q.size()), 160'd0);
    check("commit1_drained", 160'(commit1_q.size()), 160'd0);
    check("reads_drained",   160'(read_exp_q.size()), 160'd0);
    check("obs_drained",     160'(obs_q.size()), 160'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_coef_regfile.md
SPI_COEF_REGFILE -- requirements
Module: spi_coef_regfile

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of coefficient channels.
REQ-002 SHALL have parameter TAPS, default 8, meaning coefficients per channel; NUM_CH*TAPS SHALL be 126 or less.
REQ-003 SHALL have parameter COEF_W, default 5, meaning coefficient width in bits, range 1..24.
REQ-004 SHALL have port clock, input, 1 bit: single system clock; one clock, all state on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port SCLK, input, 1 bit: SPI clock, asynchronous to clock, mode 0.
REQ-007 SHALL have port MOSI, input, 1 bit: serial data in, MSB first.
REQ-008 SHALL have port ss, input, 1 bit: slave select, active low.
REQ-009 SHALL have port MISO, output, 1 bit: serial read data.
REQ-010 SHALL have port coef, output, NUM_CH*TAPS*COEF_W bits: active coefficients; index k = ch*TAPS+tap occupies bits [k*COEF_W +: COEF_W].
REQ-011 SHALL have port commit_pulse, output, 1 bit: one-cycle pulse on active-bank update.
REQ-012 SHALL have port err_cnt, output, 8 bits: count of aborted frames.

Function
REQ-013 SHALL pass SCLK, MOSI and ss each through a 2-flop synchroniser, then detect SCLK edges against a third flop; clock SHALL be at least 4x the SCLK frequency.
REQ-014 SHALL use a 32-bit frame: bit 31 R/W (1 = write), bits 30:24 address, bits 23:0 data; MOSI SHALL be sampled on each detected SCLK rise while ss is low.
REQ-015 SHALL keep a 6-bit bit counter; it clears while ss is high and increments on each sampled rise up to 32, then saturates; bits beyond 32 SHALL be ignored.
REQ-016 SHALL hold a shadow bank and an active bank of NUM_CH*TAPS x COEF_W registers; coef SHALL reflect the active bank only.
REQ-017 SHALL, on a write frame with address < NUM_CH*TAPS, write data[COEF_W-1:0] to the addressed shadow register exactly one clock after the 32nd sampled rise.
REQ-018 SHALL, on a write frame to address 0x7F with data[0]=1, copy the whole shadow bank to the active bank and assert commit_pulse for one clock, both one clock after the 32nd rise; data[0]=0 SHALL do nothing.
REQ-019 SHALL ignore writes to 0x7E and to unmapped addresses, with no state change.
REQ-020 SHALL, on a read frame, load a 24-bit transmit register in the same clock as the 8th sampled rise, from one of three sources.
REQ-020a For a mapped address, the source SHALL be the zero-extended shadow value.
REQ-020b For address 0x7E, the source SHALL be the zero-extended err_cnt.
REQ-020c For any other address, the source SHALL be zero.
REQ-021 SHALL drive MISO from the transmit register MSB, shifting left on each detected SCLK fall while the bit counter is in 9..31.
REQ-022 SHALL hold MISO at 0 while ss is high, during bits 1..8, and throughout write frames.
REQ-023 SHALL treat a synchronised ss rise with the bit counter not equal to 0 or 32 as an aborted frame: no write, no commit, and err_cnt increments, saturating at 255.
REQ-024 SHALL, when ss rises with the bit counter at 32, complete the frame normally with no error; ss low with no SCLK edges SHALL have no effect.

Reset
REQ-025 SHALL, while reset is high, clear both banks, the bit counter, the shift and transmit registers, err_cnt, commit_pulse and MISO to 0.
REQ-026 SHALL reset the synchroniser flops to 0 for SCLK and MOSI and to 1 for ss.
REQ-027 SHALL discard any frame in progress when reset is asserted; the first frame after reset SHALL start on the first ss fall.

Verification
REQ-028 SHALL check that writing 0x00000013 to address 0x05 leaves coef unchanged, then committing with 0xFF000001 sets coef[29:25]=0x13 and commit_pulse high for exactly 1 clock.
REQ-029 SHALL check that a read of address 0x05 after REQ-028 returns MISO bits 9..32 equal to 0x000013, with MISO 0 during bits 1..8.
REQ-030 SHALL check that raising ss after 17 bits of a write to 0x02 leaves shadow unchanged and sets err_cnt to 1; 300 such aborts SHALL read 0x7E as 0x0000FF.
REQ-031 SHALL check that writes to 0x40 and 0x7E change nothing and that a read of 0x40 returns 0x000000.
REQ-032 SHALL check that asserting reset after 20 bits of a write, then sending a full write and a commit, gives coef equal to the new frame only and err_cnt = 0.
REQ-033 SHALL check that with NUM_CH=2, TAPS=3, COEF_W=12, writing 0xABC to address 5 and committing gives coef[71:60]=0xABC.
